ex_stage_pipe: RTL

EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

---
 rtl/ex_pkg.sv | 62 ++++++
 rtl/ex_mul_iter.sv | 58 +++++
 rtl/ex_stage_pipe.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation classes, funct codes,
// FSM states and the ALU decode helper. MUL exists only with EX_STAGE_PIPE_MDU_EN.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FULL = 2'd1
`ifdef EX_STAGE_PIPE_MDU_EN
    , MUL = 2'd2
`endif
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_MUL
  } alu_op_e;

  function automatic alu_op_e decodeAlu(input logic [1:0] aluop, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    case (aluop)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: op = ALU_ADD;
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_AND: op = ALU_AND;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_NOR: op = ALU_NOR;
          FUNCT_SLT: op = ALU_SLT;
`ifdef EX_STAGE_PIPE_MDU_EN
          FUNCT_MUL: op = ALU_MUL;
`else
          FUNCT_MUL: op = ALU_ADD;
`endif
          default:   op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for XLEN cycles,
// returning the low XLEN bits. o_done pulses during the final iteration.
module ex_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   r_count;
  logic            r_active;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] w_nextAcc;
  logic            w_lastIter;

  // The result is taken combinationally from the last addition so that the
  // owner can register it on the same edge that ends the iteration.
  assign w_nextAcc  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_lastIter = r_active && (r_count == CW'(XLEN - 1));
  assign o_done     = w_lastIter;
  assign o_result   = w_nextAcc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_active <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_abort) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_count  <= '0;
      r_active <= 1'b1;
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (r_active) begin
      r_acc    <= w_nextAcc;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= w_lastIter ? '0 : r_count + 1'b1;
      if (w_lastIter) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute pipeline stage with valid/ready handshakes on both sides and an output
// holding register. The iterative MUL path is built only with EX_STAGE_PIPE_MDU_EN.
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            branch,
  input  logic            memread,
  input  logic            memwrite,
  input  logic            memtoreg,
  input  logic            regwrite,
  input  logic            regdst,
  input  logic            alusrc,
  input  logic [1:0]      aluop,
  input  logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] seimm,
  input  logic [RAW-1:0]  rt,
  input  logic [RAW-1:0]  rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            branch_out,
  output logic            memread_out,
  output logic            memwrite_out,
  output logic            memtoreg_out,
  output logic            regwrite_out,
  output logic [XLEN-1:0] btarget,
  output logic [XLEN-1:0] alurslt,
  output logic [XLEN-1:0] data2_out,
  output logic            zero,
  output logic [RAW-1:0]  wrreg_out,
  output logic            busy
);

  state_e          r_state;
  state_e          w_nextState;
  state_e          w_acceptTarget;
  alu_op_e         w_aluOp;
  logic [XLEN-1:0] w_opB;
  logic [XLEN-1:0] w_aluResult;
  logic [XLEN-1:0] w_btarget;
  logic            w_accept;
  logic            w_isMul;

  logic [4:0]      r_ctrl;
  logic [XLEN-1:0] r_btarget;
  logic [XLEN-1:0] r_alurslt;
  logic [XLEN-1:0] r_data2;
  logic            r_zero;
  logic [RAW-1:0]  r_wrreg;

  assign w_opB     = alusrc ? seimm : data2;
  assign w_btarget = pc4 + (seimm << 2);
  assign w_aluOp   = decodeAlu(aluop, seimm[5:0]);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_aluResult = data1 + w_opB;
    case (w_aluOp)
      ALU_ADD: w_aluResult = data1 + w_opB;
      ALU_SUB: w_aluResult = data1 - w_opB;
      ALU_AND: w_aluResult = data1 & w_opB;
      ALU_OR:  w_aluResult = data1 | w_opB;
      ALU_NOR: w_aluResult = ~(data1 | w_opB);
      ALU_SLT: w_aluResult = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(w_opB))};
      default: w_aluResult = data1 + w_opB;
    endcase
  end

`ifdef EX_STAGE_PIPE_MDU_EN
  logic            w_mulDone;
  logic [XLEN-1:0] w_mulResult;

  assign w_isMul        = (w_aluOp == ALU_MUL);
  assign w_acceptTarget = w_isMul ? MUL : FULL;

  ex_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && w_isMul),
    .i_abort  (flush),
    .i_a      (data1),
    .i_b      (w_opB),
    .o_done   (w_mulDone),
    .o_result (w_mulResult)
  );
`else
  assign w_isMul        = 1'b0;
  assign w_acceptTarget = FULL;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_accept) w_nextState = w_acceptTarget;
        FULL: if (out_ready) w_nextState = w_accept ? w_acceptTarget : IDLE;
`ifdef EX_STAGE_PIPE_MDU_EN
        MUL:  if (w_mulDone) w_nextState = FULL;
`endif
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Flush blocks acceptance so a simultaneous upstream transfer is dropped.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: in_ready = !flush;
      FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !flush;
      end
`ifdef EX_STAGE_PIPE_MDU_EN
      MUL:  busy = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_btarget <= '0;
      r_alurslt <= '0;
      r_data2   <= '0;
      r_zero    <= 1'b0;
      r_wrreg   <= '0;
    end else begin
      if (w_accept) begin
        r_ctrl    <= {branch, memread, memwrite, memtoreg, regwrite};
        r_btarget <= w_btarget;
        r_data2   <= data2;
        r_wrreg   <= regdst ? rd : rt;
        if (!w_isMul) begin
          r_alurslt <= w_aluResult;
          r_zero    <= (w_aluResult == '0);
        end
      end
`ifdef EX_STAGE_PIPE_MDU_EN
      else if (w_mulDone && !flush) begin
        r_alurslt <= w_mulResult;
        r_zero    <= (w_mulResult == '0);
      end
`endif
    end
  end

  assign {branch_out, memread_out, memwrite_out, memtoreg_out, regwrite_out} = r_ctrl;
  assign btarget   = r_btarget;
  assign alurslt   = r_alurslt;
  assign data2_out = r_data2;
  assign zero      = r_zero;
  assign wrreg_out = r_wrreg;

endmodule
